// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encodings, the
// relock counter width and a saturating increment helper.
// Latency: n/a (package).  Backpressure: n/a (package).
// The encodings are visible to software through state_o, so keep them fixed.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3
  } pll_sup_state_e;

  localparam int RELOCK_W = 8;
  localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

  // Increment that sticks at all-ones so a flapping PLL cannot wrap the
  // event count back to a harmless-looking value.
  function automatic logic [RELOCK_W-1:0] relock_sat_inc(input logic [RELOCK_W-1:0] v);
    logic [RELOCK_W-1:0] r;
    r = (v == RELOCK_MAX) ? v : v + RELOCK_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for bringing an asynchronous level into clkin.
// Latency: 2 clkin edges from d to q.  Backpressure: none (level signal, no handshake).
// Ports: clkin - destination clock; reset - async active-high, clears both flops;
//        d - asynchronous input level; q - synchronized level.
module sync_2ff (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the pixel-clock PLL: pulses its RESET, qualifies LOCK, and holds video logic in reset until lock is stable.
// Latency: pll_lock to any output is 3 clkin edges (2 synchronizer + 1 registered decision).
// Backpressure: none; all outputs are registered levels with no handshake.
//
// Ports: clkin      - 50 MHz reference clock, the only clock
//        reset      - async active-high reset
//        pll_lock   - PLL LOCK, asynchronous to clkin
//        pll_reset  - to PLL RESET, active-high
//        video_rst  - active-high reset for downstream video logic (deasserts synchronously to clkin)
//        locked_ok  - high while in RUN
//        relock_cnt - saturating count of lock-loss and lock-timeout events
//        state_o    - current state encoding, for debug
//
// Build option: define PLL_SUP_LOSS_FILTER_EN to debounce lock loss in RUN over
// LOSS_FILTER consecutive low samples; without it a single low sample exits RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOSS_FILTER    = 4,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int          CNT_W          = 17
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic                video_rst,
  output logic                locked_ok,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic [2:0]          state_o
);

  // Terminal counts for the shared cycle counter.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Lock synchronizer
  // ---------------------------------------------------------------------------
  logic lock_s;

  sync_2ff u_lock_sync (
    .clkin (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  pll_sup_state_e      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_reset_d, video_rst_d, locked_ok_d;

`ifdef PLL_SUP_LOSS_FILTER_EN
  // The loss counter only has to reach LOSS_FILTER-1; the LOSS_FILTER-th
  // consecutive low sample is the one that triggers the exit.
  localparam int LOSS_W = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [LOSS_W-1:0] LOSS_ONE  = LOSS_W'(1);

  logic [LOSS_W-1:0] loss_q, loss_d;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end
`else
  // LOSS_FILTER has no effect in this build; tie it off so it is visibly unused.
  logic unused_loss_filter;
  assign unused_loss_filter = (LOSS_FILTER == 0);
`endif

  // State register (process 1 of 3). Output flops live here too so that every
  // output is a flop with no combinational path from pll_lock.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      relock_q  <= '0;
      pll_reset <= 1'b1;
      video_rst <= 1'b1;
      locked_ok <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      pll_reset <= pll_reset_d;
      video_rst <= video_rst_d;
      locked_ok <= locked_ok_d;
    end
  end

  // Next-state logic (process 2 of 3).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
`ifdef PLL_SUP_LOSS_FILTER_EN
    loss_d   = '0;  // only RUN keeps a running loss count
`endif

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_LOCK: begin
        // Lock is tested before the timeout so a lock arriving on the very
        // last cycle is honoured rather than thrown away by a re-pulse.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = ST_PLL_RST;
          cnt_d    = '0;
          relock_d = relock_sat_inc(relock_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STABLE: begin
        // A dropout here just restarts qualification; the PLL is not reset
        // and it is not counted as a relock event.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
`ifdef PLL_SUP_LOSS_FILTER_EN
        if (lock_s) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          state_d  = ST_PLL_RST;
          cnt_d    = '0;
          relock_d = relock_sat_inc(relock_q);
        end else begin
          loss_d = loss_q + LOSS_ONE;
        end
`else
        if (!lock_s) begin
          state_d  = ST_PLL_RST;
          cnt_d    = '0;
          relock_d = relock_sat_inc(relock_q);
        end
`endif
      end

      default: begin
        // Unused encodings fall back to a fresh PLL reset pulse.
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode (process 3 of 3). Decoded from the next state so the
  // registered outputs change on the same edge as the state they belong to.
  always_comb begin
    pll_reset_d = 1'b0;
    video_rst_d = 1'b1;
    locked_ok_d = 1'b0;
    case (state_d)
      ST_PLL_RST:   pll_reset_d = 1'b1;
      ST_WAIT_LOCK: pll_reset_d = 1'b0;
      ST_STABLE:    pll_reset_d = 1'b0;
      ST_RUN: begin
        video_rst_d = 1'b0;
        locked_ok_d = 1'b1;
      end
      default:      pll_reset_d = 1'b1;
    endcase
  end

  assign relock_cnt = relock_q;
  assign state_o    = state_q;

endmodule
